// File: rtl/mdio_pkg.sv
// Shared constants, request struct and helpers for the MDIO link poller.
// Word layout: [31:24]=MDIO base, [12:8]=PHY, [6:2]=register; data bytes swapped.
package mdio_pkg;

    localparam logic [7:0] MDIO_BASE     = 8'h07;
    localparam logic [4:0] REG_BMCR      = 5'd0;
    localparam logic [4:0] REG_BMSR      = 5'd1;
    localparam int         BMSR_LINK_BIT = 2;
    // BMSR low byte lands in word bits [15:8] after the master's swap
    localparam int         WORD_LINK_BIT = 8 + BMSR_LINK_BIT;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CPU  = 3'd1;
    localparam logic [2:0] S_POLL = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_INIT = 3'd4;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mdio_req_t;

    function automatic logic [15:0] mdio_swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] mdio_addr(input logic [4:0] phy, input logic [4:0] regn);
        return {MDIO_BASE, 11'b0, phy, 1'b0, regn, 2'b00};
    endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running reload down-counter that raises a sticky poll-pending flag on expiry.
// Expiries while blocked (poll in flight) or already pending are dropped, never queued.
module mdio_poll_timer #(
    parameter logic [31:0] POLL_INTERVAL = 32'd1_000_000
) (
    input  logic clk,
    input  logic arst_n,
    input  logic block_i,
    input  logic clear_i,
    output logic pending_o
);

    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        expire;

    always_comb begin
        expire    = (cnt_q == 32'd0);
        cnt_d     = expire ? POLL_INTERVAL - 32'd1 : cnt_q - 32'd1;
        pending_d = pending_q;
        if (expire && !block_i) pending_d = 1'b1;
        if (clear_i)            pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q     <= POLL_INTERVAL - 32'd1;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/mdio_link_poller.sv
// Shares one MDIO master between CPU iomem accesses and a periodic BMSR link poll.
// Define MDIO_INIT_EN to issue a single INIT_BMCR write to BMCR right after reset.
module mdio_link_poller
    import mdio_pkg::*;
#(
    parameter logic [31:0] POLL_INTERVAL = 32'd1_000_000,
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [15:0] INIT_BMCR     = 16'h1200
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_wstrb,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        link_up,
    output logic        link_change,
    output logic        poll_busy
);

`ifdef MDIO_INIT_EN
    localparam logic [2:0] RST_STATE = S_INIT;
`else
    localparam logic [2:0] RST_STATE = S_IDLE;
`endif

    logic [2:0]  state_q, state_d;
    mdio_req_t   req_q, req_d;
    logic        mvalid_q, mvalid_d;
    logic        sready_q, sready_d;
    logic [31:0] srdata_q, srdata_d;
    logic        link_q, link_d;
    logic        chg_q, chg_d;
    logic        busy_q, busy_d;
    logic        poll_pending, pend_clr, cpu_hit;

    mdio_poll_timer #(.POLL_INTERVAL(POLL_INTERVAL)) u_timer (
        .clk      (clk),
        .arst_n   (arst_n),
        .block_i  (busy_q),
        .clear_i  (pend_clr),
        .pending_o(poll_pending)
    );

    assign cpu_hit = s_valid && (s_addr[31:24] == MDIO_BASE) && !sready_q;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        mvalid_d = mvalid_q;
        sready_d = 1'b0;
        srdata_d = srdata_q;
        link_d   = link_q;
        chg_d    = 1'b0;
        busy_d   = busy_q;
        pend_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                // CPU has priority over a poll that becomes pending the same cycle
                if (cpu_hit) begin
                    req_d    = '{wstrb: s_wstrb, addr: s_addr, wdata: s_wdata};
                    mvalid_d = 1'b1;
                    state_d  = S_CPU;
                end else if (poll_pending) begin
                    req_d    = '{wstrb: 4'b0, addr: mdio_addr(PHY_ADDR, REG_BMSR), wdata: 32'h0};
                    mvalid_d = 1'b1;
                    busy_d   = 1'b1;
                    pend_clr = 1'b1;
                    state_d  = S_POLL;
                end
            end
            S_CPU: begin
                if (m_ready) begin
                    mvalid_d = 1'b0;
                    srdata_d = m_rdata;
                    sready_d = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_POLL: begin
                if (m_ready) begin
                    mvalid_d = 1'b0;
                    busy_d   = 1'b0;
                    link_d   = m_rdata[WORD_LINK_BIT];
                    chg_d    = (m_rdata[WORD_LINK_BIT] != link_q);
                    state_d  = S_GAP;
                end
            end
            S_GAP: state_d = S_IDLE;
            S_INIT: begin
                if (!mvalid_q) begin
                    req_d    = '{wstrb: 4'b0011, addr: mdio_addr(PHY_ADDR, REG_BMCR),
                                 wdata: {16'h0, mdio_swap16(INIT_BMCR)}};
                    mvalid_d = 1'b1;
                end else if (m_ready) begin
                    mvalid_d = 1'b0;
                    state_d  = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= RST_STATE;
            req_q    <= '0;
            mvalid_q <= 1'b0;
            sready_q <= 1'b0;
            srdata_q <= 32'h0;
            link_q   <= 1'b0;
            chg_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            mvalid_q <= mvalid_d;
            sready_q <= sready_d;
            srdata_q <= srdata_d;
            link_q   <= link_d;
            chg_q    <= chg_d;
            busy_q   <= busy_d;
        end
    end

    assign s_ready     = sready_q;
    assign s_rdata     = srdata_q;
    assign m_valid     = mvalid_q;
    assign m_wstrb     = req_q.wstrb;
    assign m_addr      = req_q.addr;
    assign m_wdata     = req_q.wdata;
    assign link_up     = link_q;
    assign link_change = chg_q;
    assign poll_busy   = busy_q;

endmodule
